// File: rtl/morse_keyer_seq.sv
// morse_keyer_seq
// Beacon Morse sequencer. Pulls symbol codes (dot, dash, character gap,
// word gap, end) over a valid/ready handshake and times every element in
// whole dit units of baud_tick pulses. It drives the mark/space tone select
// (key) and the transmit enable (ptt) for the DDS path. All outputs are
// registered.

// Invariant checker for the keyer outputs; carries no functional logic.
module morse_keyer_seq_chk (
    input  logic clk,
    input  logic rst,
    input  logic sym_ready,
    input  logic key,
    input  logic ptt,
    input  logic busy,
    input  logic msg_done
);

    // The mark tone only sounds inside a timed element while transmitting.
    a_key_in_element: assert property (@(posedge clk) disable iff (rst)
        key |-> (busy && ptt));

    // A symbol is only offered while no element is being timed.
    a_ready_not_busy: assert property (@(posedge clk) disable iff (rst)
        sym_ready |-> !busy);

    // End of message leaves the keyer idle with the transmitter released.
    a_done_idle: assert property (@(posedge clk) disable iff (rst)
        msg_done |-> (!busy && !ptt && !key));

    // The end-of-message indication lasts exactly one cycle.
    a_done_single: assert property (@(posedge clk) disable iff (rst)
        msg_done |=> !msg_done);

endmodule

module morse_keyer_seq #(
    parameter int unsigned DIT_TICKS    = 144,
    parameter int unsigned END_GAP_DITS = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic       enable,
    input  logic       sym_valid,
    input  logic [2:0] sym_code,
    output logic       sym_ready,
    output logic       key,
    output logic       ptt,
    output logic       busy,
    output logic       msg_done
);

    // Last tick index inside one dit unit.
    localparam logic [15:0] DIT_LAST = 16'(DIT_TICKS - 32'd1);

    // Element lengths in dit units.
    localparam logic [7:0] DOT_UNITS        = 8'd1;
    localparam logic [7:0] DASH_UNITS       = 8'd3;
    localparam logic [7:0] ELEM_SPACE_UNITS = 8'd1;
    // The inter-element space that trails every mark supplies one unit,
    // so a character gap adds 2 (total 3) and a word gap adds 6 (total 7).
    localparam logic [7:0] CHAR_GAP_UNITS   = 8'd2;
    localparam logic [7:0] WORD_GAP_UNITS   = 8'd6;
    localparam logic [7:0] END_UNITS        = 8'(END_GAP_DITS);

    // Symbol codes.
    localparam logic [2:0] CODE_DOT      = 3'd0;
    localparam logic [2:0] CODE_DASH     = 3'd1;
    localparam logic [2:0] CODE_CHAR_GAP = 3'd2;
    localparam logic [2:0] CODE_WORD_GAP = 3'd3;
    localparam logic [2:0] CODE_END      = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_MARK    = 3'd2,
        ST_SPACE   = 3'd3,
        ST_END_GAP = 3'd4
    } state_t;

    state_t      state_r;
    logic [15:0] tick_cnt_r;
    logic [7:0]  unit_cnt_r;
    logic        sym_ready_r;
    logic        key_r;
    logic        ptt_r;
    logic        busy_r;
    logic        msg_done_r;

    logic        xfer_s;
    logic        tick_last_s;
    logic        expire_s;
    logic [15:0] tick_next_s;
    logic [7:0]  unit_next_s;

    // Handshake: a symbol moves only when the registered ready is presented in FETCH.
    always_comb begin
        xfer_s = 1'b0;
        if (state_r == ST_FETCH) begin
            xfer_s = sym_valid && sym_ready_r;
        end else begin
            xfer_s = 1'b0;
        end
    end

    // Dit-unit countdown shared by all timed states; expire_s marks the final tick.
    always_comb begin
        tick_last_s = (tick_cnt_r == DIT_LAST);
        tick_next_s = tick_cnt_r;
        unit_next_s = unit_cnt_r;
        expire_s    = 1'b0;
        if (baud_tick && tick_last_s) begin
            tick_next_s = 16'd0;
            unit_next_s = unit_cnt_r - 8'd1;
            expire_s    = (unit_cnt_r == 8'd1);
        end else if (baud_tick) begin
            tick_next_s = tick_cnt_r + 16'd1;
            unit_next_s = unit_cnt_r;
            expire_s    = 1'b0;
        end else begin
            tick_next_s = tick_cnt_r;
            unit_next_s = unit_cnt_r;
            expire_s    = 1'b0;
        end
    end

    // Sequencer FSM with its counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            tick_cnt_r  <= 16'd0;
            unit_cnt_r  <= 8'd0;
            sym_ready_r <= 1'b0;
            key_r       <= 1'b0;
            ptt_r       <= 1'b0;
            busy_r      <= 1'b0;
            msg_done_r  <= 1'b0;
        end else begin
            msg_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    sym_ready_r <= enable;
                    if (enable) begin
                        state_r <= ST_FETCH;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_FETCH: begin
                    if (xfer_s) begin
                        case (sym_code)
                            CODE_DOT: begin
                                state_r     <= ST_MARK;
                                unit_cnt_r  <= DOT_UNITS;
                                tick_cnt_r  <= 16'd0;
                                key_r       <= 1'b1;
                                ptt_r       <= 1'b1;
                                busy_r      <= 1'b1;
                                sym_ready_r <= 1'b0;
                            end
                            CODE_DASH: begin
                                state_r     <= ST_MARK;
                                unit_cnt_r  <= DASH_UNITS;
                                tick_cnt_r  <= 16'd0;
                                key_r       <= 1'b1;
                                ptt_r       <= 1'b1;
                                busy_r      <= 1'b1;
                                sym_ready_r <= 1'b0;
                            end
                            CODE_CHAR_GAP: begin
                                state_r     <= ST_SPACE;
                                unit_cnt_r  <= CHAR_GAP_UNITS;
                                tick_cnt_r  <= 16'd0;
                                key_r       <= 1'b0;
                                ptt_r       <= 1'b1;
                                busy_r      <= 1'b1;
                                sym_ready_r <= 1'b0;
                            end
                            CODE_WORD_GAP: begin
                                state_r     <= ST_SPACE;
                                unit_cnt_r  <= WORD_GAP_UNITS;
                                tick_cnt_r  <= 16'd0;
                                key_r       <= 1'b0;
                                ptt_r       <= 1'b1;
                                busy_r      <= 1'b1;
                                sym_ready_r <= 1'b0;
                            end
                            CODE_END: begin
                                state_r     <= ST_END_GAP;
                                unit_cnt_r  <= END_UNITS;
                                tick_cnt_r  <= 16'd0;
                                key_r       <= 1'b0;
                                ptt_r       <= 1'b1;
                                busy_r      <= 1'b1;
                                sym_ready_r <= 1'b0;
                            end
                            default: begin
                                // Reserved code: swallowed without timing or output change.
                                state_r     <= ST_FETCH;
                                sym_ready_r <= enable;
                            end
                        endcase
                    end else if (!enable) begin
                        state_r     <= ST_IDLE;
                        sym_ready_r <= 1'b0;
                    end else begin
                        state_r     <= ST_FETCH;
                        sym_ready_r <= 1'b1;
                    end
                end

                ST_MARK: begin
                    if (expire_s) begin
                        state_r    <= ST_SPACE;
                        unit_cnt_r <= ELEM_SPACE_UNITS;
                        tick_cnt_r <= 16'd0;
                        key_r      <= 1'b0;
                    end else begin
                        tick_cnt_r <= tick_next_s;
                        unit_cnt_r <= unit_next_s;
                    end
                end

                ST_SPACE: begin
                    if (expire_s) begin
                        state_r     <= ST_FETCH;
                        unit_cnt_r  <= 8'd0;
                        tick_cnt_r  <= 16'd0;
                        busy_r      <= 1'b0;
                        sym_ready_r <= enable;
                    end else begin
                        tick_cnt_r <= tick_next_s;
                        unit_cnt_r <= unit_next_s;
                    end
                end

                ST_END_GAP: begin
                    if (expire_s) begin
                        state_r     <= ST_IDLE;
                        unit_cnt_r  <= 8'd0;
                        tick_cnt_r  <= 16'd0;
                        busy_r      <= 1'b0;
                        ptt_r       <= 1'b0;
                        msg_done_r  <= 1'b1;
                        sym_ready_r <= 1'b0;
                    end else begin
                        tick_cnt_r <= tick_next_s;
                        unit_cnt_r <= unit_next_s;
                    end
                end

                default: begin
                    state_r     <= ST_IDLE;
                    tick_cnt_r  <= 16'd0;
                    unit_cnt_r  <= 8'd0;
                    sym_ready_r <= 1'b0;
                    key_r       <= 1'b0;
                    ptt_r       <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign sym_ready = sym_ready_r;
    assign key       = key_r;
    assign ptt       = ptt_r;
    assign busy      = busy_r;
    assign msg_done  = msg_done_r;

    morse_keyer_seq_chk u_chk (
        .clk       (clk),
        .rst       (rst),
        .sym_ready (sym_ready_r),
        .key       (key_r),
        .ptt       (ptt_r),
        .busy      (busy_r),
        .msg_done  (msg_done_r)
    );

endmodule

// File: doc/morse_keyer_seq.md
Name: morse_keyer_seq

Overview:
Sequences the beacon Morse message onto the CPFSK modulator. Consumes a stream of symbol codes (dot, dash, character gap, word gap, end of message) over a valid/ready handshake. Times each element in whole dit units using the single-cycle baud tick derived from the clock divider. Drives the mark/space tone select and the PTT enable for the DDS path.

Parameters:
DIT_TICKS, 144, baud_tick pulses per dit unit (1200 Hz ticks ≈ 10 WPM); legal range 1..65535
END_GAP_DITS, 50, dit units of space after END before msg_done; legal range 1..255

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
baud_tick  input  1  single-cycle enable at baud rate, synchronous to clk
enable  input  1  permits starting/continuing symbol fetch
sym_valid  input  1  sym_code is valid
sym_code  input  3  0 DOT, 1 DASH, 2 CHAR_GAP, 3 WORD_GAP, 4 END, 5-7 reserved
sym_ready  output  1  controller accepts a symbol this cycle
key  output  1  1 = mark tone, 0 = space tone (drives DDS tone select)
ptt  output  1  transmit active; DDS output enabled
busy  output  1  FSM not in IDLE/FETCH
msg_done  output  1  one-cycle pulse at end of END gap

Behaviour:
- Reset (async, any state): state=IDLE, all outputs 0, tick_cnt=0, unit_cnt=0.
- States: IDLE, FETCH, MARK, SPACE, END_GAP.
- IDLE: enable=1 -> FETCH next cycle. sym_ready=0.
- FETCH: sym_ready=1 (registered, equals state==FETCH && enable). Transfer = sym_valid && sym_ready.
  - enable=0 in FETCH -> IDLE; no symbol consumed; ptt unchanged.
  - DOT: MARK with unit_cnt=1; DASH: MARK with unit_cnt=3; ptt<=1 on first transfer.
  - CHAR_GAP: SPACE with unit_cnt=2; WORD_GAP: SPACE with unit_cnt=6.
  - END: END_GAP with unit_cnt=END_GAP_DITS.
  - Codes 5-7: consumed, stay in FETCH, no time, no output change.
- Outputs registered: key rises the cycle after a DOT/DASH transfer.
- Timing: tick_cnt cleared on entry to each timed state; a baud_tick in the transfer cycle is ignored. Each baud_tick in a timed state increments tick_cnt; at tick_cnt==DIT_TICKS-1 with baud_tick, tick_cnt->0 and unit_cnt decrements. When unit_cnt reaches 0 the state exits on that same edge.
- MARK: key=1. On expiry -> SPACE with unit_cnt=1 (inter-element space), key=0 the next cycle.
- SPACE: key=0. On expiry -> FETCH.
- Gap totals: DOT = 1 mark + 1 space; DASH = 3 + 1; DOT then CHAR_GAP gives 3 space units; WORD_GAP gives 7.
- END_GAP: key=0, ptt stays 1. On expiry: msg_done=1 for exactly one cycle, ptt<=0, state -> IDLE.
- enable deasserted in MARK/SPACE/END_GAP: the current element and its trailing space finish normally. Then FETCH sees enable=0 -> IDLE, and ptt stays 1 until the next END completes or reset.
- Counter widths: tick_cnt 16 bit; unit_cnt 8 bit; no wrap possible within legal parameter ranges.
- busy=1 in MARK, SPACE, END_GAP.
- sym_valid/sym_code are don't-care outside FETCH; no transfer occurs unless sym_ready=1.

Test Plan:
- Reset mid-MARK (DIT_TICKS=4, baud_tick every 3 clk) -> all outputs 0 immediately (async), state IDLE; after release with enable=1, sym_ready=1 within 2 cycles.
- DOT, then DOT (DIT_TICKS=4) -> key high for exactly 4 baud_ticks, low for 4, high for 4. sym_ready pulses once per element; ptt=1 from the cycle after the first transfer.
- DASH, CHAR_GAP, DOT -> key high 12 ticks; low 4+8=12 ticks; high 4 ticks.
- WORD_GAP then END (END_GAP_DITS=2) -> key low 24 ticks + 8 ticks. msg_done is a single-cycle pulse on the 32nd counted tick's following edge, then ptt=0 and busy=0.
- Code 6 followed by DOT -> reserved code consumed in 1 cycle with no key change; DOT timing as normal.
- enable dropped one cycle after a DASH transfer -> 3-dit mark + 1-dit space complete, then IDLE with sym_ready=0; sym_valid held high is not consumed.
